// File: rtl/score_tick_unit.sv
// Score/tick timing cluster: rising-edge detector on sinal, modulo-M event
// counter with wrap tick, and a saturating score counter driven by that tick.
module score_tick_unit #(
  parameter int M    = 30000,
  parameter int N    = 32,
  parameter int MAX  = 7,
  parameter int NMAX = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            sinal,
  input  logic            conta,
  output logic            pulso,
  output logic [N-1:0]    q_mod,
  output logic            fim_mod,
  output logic            meio_mod,
  output logic            tick,
  output logic [NMAX-1:0] q_max,
  output logic            fim_max
);

  localparam logic [N-1:0]    LAST_MOD = N'(M - 1);
  localparam logic [N-1:0]    HALF_MOD = N'(M / 2 - 1);
  localparam logic [NMAX-1:0] SAT_MAX  = NMAX'(MAX);

  logic prev;

  // prev clears to 0 so a sinal already high at reset release still pulses once
  always_ff @(posedge clock or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= sinal;
  end

  assign pulso = sinal & ~prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      q_mod <= '0;
    else if (clear) q_mod <= '0;
    else if (conta) q_mod <= fim_mod ? '0 : q_mod + N'(1);
  end

  assign fim_mod  = (q_mod == LAST_MOD);
  assign meio_mod = (q_mod == HALF_MOD);
  assign tick     = conta & fim_mod;

  // clear wins over a simultaneous tick, so a wrap during clear is not scored
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                        q_max <= '0;
    else if (clear)                   q_max <= '0;
    else if (tick && q_max < SAT_MAX) q_max <= q_max + NMAX'(1);
  end

  assign fim_max = (q_max == SAT_MAX);

endmodule

// File: tb/tb_score_tick_unit.sv
// Self-checking bench for score_tick_unit (M=5, N=3, MAX=3, NMAX=2) against
// an enable-count reference model: q_mod = enables mod M, q_max = min(enables/M, MAX).
module tb_score_tick_unit;

  localparam int M    = 5;
  localparam int N    = 3;
  localparam int MAX  = 3;
  localparam int NMAX = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            clear = 1'b0;
  logic            sinal = 1'b0;
  logic            conta = 1'b0;
  logic            pulso;
  logic [N-1:0]    q_mod;
  logic            fim_mod;
  logic            meio_mod;
  logic            tick;
  logic [NMAX-1:0] q_max;
  logic            fim_max;

  logic [9:0] observed;
  assign observed = {pulso, q_mod, fim_mod, meio_mod, tick, q_max, fim_max};

  int checks = 0;
  int errors = 0;

  // reference model state: enables seen since last clear/reset, last sinal sample
  int   enables = 0;
  logic prev_m  = 1'b0;

  score_tick_unit #(.M(M), .N(N), .MAX(MAX), .NMAX(NMAX)) dut (
    .clock(clock), .reset(reset), .clear(clear), .sinal(sinal), .conta(conta),
    .pulso(pulso), .q_mod(q_mod), .fim_mod(fim_mod), .meio_mod(meio_mod),
    .tick(tick), .q_max(q_max), .fim_max(fim_max)
  );

  always #5 clock = ~clock;

  function automatic logic [9:0] expected();
    int   qm    = enables % M;
    int   score = enables / M;
    logic fim;
    if (score > MAX) score = MAX;
    fim = (qm == M - 1);
    return {sinal & ~prev_m, N'(qm), fim, (qm == M / 2 - 1), conta & fim,
            NMAX'(score), (score == MAX)};
  endfunction

  task automatic drive(input logic c, input logic s, input logic e);
    clear = c;
    sinal = s;
    conta = e;
  endtask

  // advance the model across one rising edge, then settle 1 time unit later
  task automatic advance();
    @(posedge clock);
    if (clear)      enables = 0;
    else if (conta) enables++;
    prev_m = sinal;
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (observed !== expected()) begin
      errors++;
      $display("[TB] FAIL reset_state: got %b expected %b", observed, expected());
    end
    reset = 1'b0;
    advance();
  endtask

  task automatic test_count();
    for (int i = 0; i < M; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      #4;
      checks++;
      if (observed !== expected()) begin
        errors++;
        $display("[TB] FAIL count cycle %0d: got %b expected %b", i, observed, expected());
      end
      advance();
    end
    checks++;
    if (q_mod !== 3'd0 || q_max !== 2'd1) begin
      errors++;
      $display("[TB] FAIL first_wrap: got q_mod=%0d q_max=%0d expected q_mod=0 q_max=1", q_mod, q_max);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 25; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      #4;
      checks++;
      if (observed !== expected()) begin
        errors++;
        $display("[TB] FAIL saturate cycle %0d: got %b expected %b", i, observed, expected());
      end
      advance();
    end
    checks++;
    if (q_max !== 2'd3 || fim_max !== 1'b1) begin
      errors++;
      $display("[TB] FAIL saturate_hold: got q_max=%0d fim_max=%b expected q_max=3 fim_max=1", q_max, fim_max);
    end
  endtask

  task automatic test_toggle();
    for (int i = 0; i < 14; i++) begin
      drive(1'b0, 1'b0, (i % 2 == 0));
      #4;
      checks++;
      if (observed !== expected()) begin
        errors++;
        $display("[TB] FAIL toggle cycle %0d: got %b expected %b", i, observed, expected());
      end
      advance();
    end
  endtask

  task automatic test_clear();
    drive(1'b1, 1'b0, 1'b0);
    advance();
    for (int i = 0; i < 2 * M + 3; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      advance();
    end
    checks++;
    if (q_mod !== 3'd3 || q_max !== 2'd2) begin
      errors++;
      $display("[TB] FAIL clear_setup: got q_mod=%0d q_max=%0d expected 3 and 2", q_mod, q_max);
    end
    // clear with a rising sinal: the edge detector must still fire
    drive(1'b1, 1'b1, 1'b0);
    #4;
    checks++;
    if (observed !== expected()) begin
      errors++;
      $display("[TB] FAIL clear_pulse: got %b expected %b", observed, expected());
    end
    advance();
    drive(1'b0, 1'b0, 1'b0);
    #4;
    checks++;
    if (observed !== expected() || q_mod !== 3'd0 || q_max !== 2'd0) begin
      errors++;
      $display("[TB] FAIL clear_result: got %b expected %b", observed, expected());
    end
    advance();
    for (int i = 0; i < M - 1; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      advance();
    end
    drive(1'b1, 1'b0, 1'b1);
    #4;
    checks++;
    if (tick !== 1'b1 || observed !== expected()) begin
      errors++;
      $display("[TB] FAIL clear_wrap_tick: got %b expected %b", observed, expected());
    end
    advance();
    drive(1'b0, 1'b0, 1'b0);
    #4;
    checks++;
    if (q_max !== 2'd0 || observed !== expected()) begin
      errors++;
      $display("[TB] FAIL clear_wrap_score: got %b expected %b", observed, expected());
    end
    advance();
  endtask

  task automatic test_edge();
    int pulses = 0;
    for (int i = 0; i < 14; i++) begin
      drive(1'b0, (i >= 1 && i <= 10) || (i >= 12), 1'b0);
      #4;
      if (pulso === 1'b1) pulses++;
      checks++;
      if (observed !== expected()) begin
        errors++;
        $display("[TB] FAIL edge cycle %0d: got %b expected %b", i, observed, expected());
      end
      advance();
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("[TB] FAIL edge_count: got %0d pulses expected 2", pulses);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0, 1'b0);
    advance();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      advance();
    end
    drive(1'b0, 1'b1, 1'b0);
    #1;
    reset   = 1'b1;
    enables = 0;
    prev_m  = 1'b0;
    #1;
    checks++;
    if (q_mod !== 3'd0 || pulso !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_reset: got q_mod=%0d pulso=%b expected q_mod=0 pulso=1", q_mod, pulso);
    end
    reset = 1'b0;
    #2;
    checks++;
    if (observed !== expected()) begin
      errors++;
      $display("[TB] FAIL reset_release: got %b expected %b", observed, expected());
    end
    advance();
    drive(1'b0, 1'b1, 1'b0);
    #4;
    checks++;
    if (pulso !== 1'b0 || observed !== expected()) begin
      errors++;
      $display("[TB] FAIL reset_single_pulse: got %b expected %b", observed, expected());
    end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
      #4;
      checks++;
      if (observed !== expected()) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: got %b expected %b", i, observed, expected());
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_saturate();
    test_toggle();
    test_clear();
    test_edge();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
